// File: rtl/stream_pkg.sv
// Shared state encoding and parameter defaults for the stream receive path.
package stream_pkg;

    localparam int CORENUM_DEF = 16;
    localparam int DW_DEF      = 32;
    localparam int ADDR_W_DEF  = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO holding a packed payload word; head is the oldest entry.
// Latency: an entry pushed at edge N is visible on head_dat_o in the cycle after N.
// Backpressure: push is ignored when full, pop when empty; push and pop may share an edge.
module stream_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_dat_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, rd_ptr_q;
    logic [1:0]   count_q;
    logic         push_ok, pop_ok;

    assign full_o     = (count_q == 2'd2);
    assign empty_o    = (count_q == 2'd0);
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign head_dat_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr_q <= ~wr_ptr_q;
            if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    // Payload storage needs no reset: it is only observed while count_q is non-zero.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/stream_rx_ctrl.sv
// Arms on run, accepts one AXI-Stream packet and scatters its beats round-robin over core memories.
// Latency: a beat accepted at edge N is presented on wr_* in the following cycle.
// Backpressure: registered src_ready drops once two beats are buffered; wr_* hold while wr_ready=0.
module stream_rx_ctrl
    import stream_pkg::*;
#(
    parameter int CORENUM = CORENUM_DEF,
    parameter int DW      = DW_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            run,
    input  logic                            src_valid,
    input  logic [DW-1:0]                   src_data,
    input  logic                            src_last,
    output logic                            src_ready,
    input  logic                            wr_ready,
    output logic                            wr_en,
    output logic [$clog2(CORENUM)-1:0]      wr_core,
    output logic [ADDR_W-1:0]               wr_addr,
    output logic [DW-1:0]                   wr_data,
    output logic                            recv_done,
    output logic [ADDR_W+$clog2(CORENUM):0] beat_cnt,
    output logic                            err
);

    localparam int CW = $clog2(CORENUM);
    localparam int BW = ADDR_W + CW + 1;

    typedef struct packed {
        logic [CW-1:0]     core;
        logic [ADDR_W-1:0] addr;
        logic [DW-1:0]     data;
    } wr_beat_t;

    rx_state_e     state_q, state_d;
    logic          src_ready_q, src_ready_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic          err_q, err_d;
    logic          accept, overflow, push, pop, arm;
    logic          fifo_full, fifo_empty, full_next, empty_next;
    wr_beat_t      push_beat, head_beat;

    assign accept   = src_valid && src_ready_q;
    // Beat index >= CORENUM * 2**ADDR_W exactly when the count MSB is set.
    assign overflow = beat_cnt_q[BW-1];
    assign push     = accept && !overflow;
    assign pop      = !fifo_empty && wr_ready;
    assign arm      = (state_q == ST_IDLE) && run;

    assign push_beat.core = beat_cnt_q[CW-1:0];
    assign push_beat.addr = beat_cnt_q[CW +: ADDR_W];
    assign push_beat.data = src_data;

    stream_skid_fifo #(
        .W ($bits(wr_beat_t))
    ) u_fifo (
        .clk_i      (clk),
        .rst_ni     (rst),
        .push_i     (push),
        .push_dat_i (push_beat),
        .pop_i      (pop),
        .head_dat_o (head_beat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // FIFO occupancy as it will be after the coming edge.
    always_comb begin
        full_next  = fifo_full;
        empty_next = fifo_empty;
        if (push && !pop) begin
            full_next  = !fifo_empty;
            empty_next = 1'b0;
        end else if (pop && !push) begin
            full_next  = 1'b0;
            empty_next = !fifo_full;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (run)                state_d = ST_RECV;
            ST_RECV:  if (accept && src_last) state_d = ST_DRAIN;
            ST_DRAIN: if (empty_next)         state_d = ST_DONE;
            ST_DONE:                          state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        src_ready = src_ready_q;
        wr_en     = !fifo_empty;
        wr_core   = head_beat.core;
        wr_addr   = head_beat.addr;
        wr_data   = head_beat.data;
        recv_done = (state_q == ST_DONE);
        beat_cnt  = beat_cnt_q;
        err       = err_q;
    end

    always_comb begin
        src_ready_d = (state_d == ST_RECV) && !full_next;
        beat_cnt_d  = beat_cnt_q;
        err_d       = err_q;
        if (arm) begin
            beat_cnt_d = '0;
            err_d      = 1'b0;
        end else if (accept) begin
            if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + BW'(1);
            if (overflow)         err_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_ready_q <= 1'b0;
            beat_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            src_ready_q <= src_ready_d;
            beat_cnt_q  <= beat_cnt_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_stream_rx_ctrl.sv
// Bench for stream_rx_ctrl: two parameterisations share stimulus, selected by sel; a queue model predicts every output.
module tb_stream_rx_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0, run = 1'b0, src_valid = 1'b0, src_last = 1'b0, wr_ready = 1'b0, sel = 1'b0;
    logic [31:0] src_data = 32'd0;
    logic        run_a, run_b;
    assign run_a = run & ~sel;
    assign run_b = run & sel;

    logic        a_src_ready, a_wr_en, a_recv_done, a_err;
    logic [1:0]  a_wr_core;
    logic [9:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic [12:0] a_beat_cnt;
    logic        b_src_ready, b_wr_en, b_recv_done, b_err;
    logic [0:0]  b_wr_core;
    logic [0:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic [2:0]  b_beat_cnt;

    stream_rx_ctrl #(.CORENUM(4), .DW(32), .ADDR_W(10)) dut_a (
        .clk(clk), .rst(rst), .run(run_a), .src_valid(src_valid), .src_data(src_data),
        .src_last(src_last), .src_ready(a_src_ready), .wr_ready(wr_ready), .wr_en(a_wr_en),
        .wr_core(a_wr_core), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .recv_done(a_recv_done), .beat_cnt(a_beat_cnt), .err(a_err));

    stream_rx_ctrl #(.CORENUM(2), .DW(32), .ADDR_W(1)) dut_b (
        .clk(clk), .rst(rst), .run(run_b), .src_valid(src_valid), .src_data(src_data),
        .src_last(src_last), .src_ready(b_src_ready), .wr_ready(wr_ready), .wr_en(b_wr_en),
        .wr_core(b_wr_core), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .recv_done(b_recv_done), .beat_cnt(b_beat_cnt), .err(b_err));

    logic        o_src_ready, o_wr_en, o_recv_done, o_err;
    logic [15:0] o_wr_core, o_wr_addr, o_beat_cnt;
    logic [31:0] o_wr_data;
    always_comb begin
        if (sel) begin
            o_src_ready = b_src_ready;  o_wr_en = b_wr_en;  o_recv_done = b_recv_done;  o_err = b_err;
            o_wr_core = {15'd0, b_wr_core};  o_wr_addr = {15'd0, b_wr_addr};
            o_beat_cnt = {13'd0, b_beat_cnt};  o_wr_data = b_wr_data;
        end else begin
            o_src_ready = a_src_ready;  o_wr_en = a_wr_en;  o_recv_done = a_recv_done;  o_err = a_err;
            o_wr_core = {14'd0, a_wr_core};  o_wr_addr = {6'd0, a_wr_addr};
            o_beat_cnt = {3'd0, a_beat_cnt};  o_wr_data = a_wr_data;
        end
    end

    // Reference model: pending writes in order, plus packet phase (0 idle, 1 recv, 2 drain, 3 done).
    typedef struct {
        int          core;
        int          addr;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];
    int   m_cores, m_cap, m_cntmax, m_phase, m_cnt;
    bit   m_rdy, m_err;
    int   n_cmp = 0, n_fail = 0, n_writes = 0;
    bit   done_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_phase = 0; m_cnt = 0; m_rdy = 1'b0; m_err = 1'b0;
    endtask

    task automatic select(input bit s);
        sel = s;
        if (s) begin m_cores = 2; m_cap = 4;    m_cntmax = 7;    end
        else   begin m_cores = 4; m_cap = 4096; m_cntmax = 8191; end
    endtask

    // Called just after a falling edge: check outputs, drive inputs, advance the model across the next rising edge.
    task automatic step(input bit r, input bit v, input logic [31:0] d, input bit l, input bit wrr, output bit acc);
        bit   pop_m;
        exp_t e;
        chk("src_ready", o_src_ready, m_rdy);
        chk("wr_en", o_wr_en, q.size() != 0);
        chk("recv_done", o_recv_done, m_phase == 3);
        chk("beat_cnt", o_beat_cnt, m_cnt);
        chk("err", o_err, m_err);
        if (q.size() != 0) begin
            chk("wr_core", o_wr_core, q[0].core);
            chk("wr_addr", o_wr_addr, q[0].addr);
            chk("wr_data", o_wr_data, q[0].data);
        end
        if (o_recv_done) done_seen = 1'b1;
        run = r; src_valid = v; src_data = d; src_last = l; wr_ready = wrr;
        pop_m = (q.size() != 0) && wrr;
        acc   = m_rdy && v;
        if (pop_m) begin
            void'(q.pop_front());
            n_writes++;
        end
        case (m_phase)
            0: if (r) begin m_phase = 1; m_cnt = 0; m_err = 1'b0; end
            1: if (acc) begin
                if (m_cnt < m_cap) begin
                    e.core = m_cnt % m_cores; e.addr = m_cnt / m_cores; e.data = d;
                    q.push_back(e);
                end else m_err = 1'b1;
                if (m_cnt < m_cntmax) m_cnt++;
                if (l) m_phase = 2;
            end
            2: if (q.size() == 0) m_phase = 3;
            default: m_phase = 0;
        endcase
        m_rdy = (m_phase == 1) && (q.size() <= 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_pkt(input string name, input int n, input bit rnd, input int vpct, input int rpct,
                           input int st_at, input int st_len, input bit run_noise);
        int          sent, cyc, exp_w, exp_c;
        bit          acc, hold, v, r, wrr;
        logic [31:0] d;
        sent = 0; cyc = 0; hold = 1'b0; v = 1'b0; d = 32'd0;
        n_writes = 0; done_seen = 1'b0;
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, acc);
        while (m_phase != 0 && cyc < 2000) begin
            if (!hold) begin
                v = (sent < n) && ($urandom_range(99) < vpct);
                d = rnd ? $urandom : 32'h10 + sent;
            end
            wrr = (cyc >= st_at && cyc < st_at + st_len) ? 1'b0 : ($urandom_range(99) < rpct);
            r   = run_noise && ($urandom_range(4) == 0);
            step(r, v, d, v && (sent == n - 1), wrr, acc);
            hold = v && !acc;
            if (acc) sent++;
            cyc++;
        end
        exp_w = (n < m_cap) ? n : m_cap;
        exp_c = (n < m_cntmax) ? n : m_cntmax;
        chk({name, "_done_seen"}, done_seen, 1'b1);
        chk({name, "_sent"}, sent, n);
        chk({name, "_writes"}, n_writes, exp_w);
        chk({name, "_beat_cnt"}, o_beat_cnt, exp_c);
        chk({name, "_err"}, o_err, n > m_cap);
    endtask

    initial begin
        bit acc;
        int sent;
        select(1'b0);
        model_reset();
        #3;
        chk("init_src_ready", o_src_ready, 1'b0);
        chk("init_wr_en", o_wr_en, 1'b0);
        chk("init_beat_cnt", o_beat_cnt, 0);
        @(negedge clk);
        rst = 1'b1;

        run_pkt("basic", 8, 1'b0, 100, 100, -1, 0, 1'b0);
        run_pkt("stall", 12, 1'b0, 100, 100, 3, 5, 1'b0);
        run_pkt("single", 1, 1'b0, 100, 100, -1, 0, 1'b0);
        for (int p = 0; p < 5; p++) run_pkt("rand", $urandom_range(1, 20), 1'b1, 70, 60, -1, 0, 1'b1);

        select(1'b1);
        run_pkt("ovf", 6, 1'b0, 100, 100, -1, 0, 1'b0);
        run_pkt("sat", 9, 1'b1, 80, 70, -1, 0, 1'b1);

        // Reset in the middle of a packet with beats still buffered.
        select(1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, acc);
        sent = 0;
        for (int c = 0; c < 50 && sent < 3; c++) begin
            step(1'b0, 1'b1, 32'hA0 + sent, 1'b0, (c % 3) == 2, acc);
            if (acc) sent++;
        end
        chk("pre_rst_sent", sent, 3);
        #2 rst = 1'b0;
        #1;
        chk("rst_src_ready", o_src_ready, 1'b0);
        chk("rst_wr_en", o_wr_en, 1'b0);
        chk("rst_recv_done", o_recv_done, 1'b0);
        chk("rst_beat_cnt", o_beat_cnt, 0);
        chk("rst_err", o_err, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b1, 32'hBAD, 1'b0, 1'b1, acc);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, acc);
        run_pkt("post_rst", 2, 1'b0, 100, 100, -1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
